divider_seq_n: RTL and testbench

Sequential unsigned restoring divider: accepts an N-bit dividend and divisor and produces an N-bit quotient and remainder, one quotient bit per clock. It is the multi-cycle consumer of `subtractor_n`. Each iteration instantiates an (N+1)-bit `subtractor_n` for the trial subtraction and uses its difference MSB as the restore decision. It sits beside the ALU in the execute stage and serves DIV/REM operations, stalling the pipeline via `busy`.

---
 rtl/divider_seq_n_if.sv | 24 ++
 rtl/divider_seq_n.sv | 139 +++++++++++++
 tb/tb_divider_seq_n.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/divider_seq_n_if.sv
// Handshake and operand/result bundle for the sequential divider.
// master drives requests and operands; slave (the divider) returns status and results.
interface divider_seq_n_if #(
   parameter int unsigned N = 32
);
   logic         start;
   logic [N-1:0] dividend;
   logic [N-1:0] divisor;
   logic         busy;
   logic         done;
   logic [N-1:0] quotient;
   logic [N-1:0] remainder;
   logic         div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/divider_seq_n.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Optional zero-divisor fast path and error flag enabled by DIVIDER_SEQ_DIVZERO_EN.

// Plain W-bit difference used for the trial subtraction.
module subtractor_n #(
   parameter int unsigned W = 33
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] diff
);
   assign diff = a - b;
endmodule

module divider_seq_n #(
   parameter int unsigned N = 32
) (
   input  logic               clk,
   input  logic               rst,
   divider_seq_n_if.slave     bus
);
   localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_r, state_nxt;
   logic [CW-1:0] cnt_r;
   logic [N-1:0]  rem_r;
   logic [N-1:0]  q_r;
   logic [N-1:0]  dsr_r;
   logic          busy_r;
   logic          done_r;
   logic [N-1:0]  quotient_r;
   logic [N-1:0]  remainder_r;
   logic          dbz_r;

   logic [N:0]    t_val;
   logic [N:0]    d_val;
   logic          q_bit;
   logic [N-1:0]  q_nxt;
   logic [N-1:0]  r_nxt;
   logic          last_step;
   logic          div_zero_c;

   // Trial subtraction; a restored step always leaves R below 2^N, so N bits suffice
   assign t_val = {rem_r, q_r[N-1]};

   subtractor_n #(.W(N + 1)) u_sub (
      .a    (t_val),
      .b    ({1'b0, dsr_r}),
      .diff (d_val)
   );

   assign q_bit     = ~d_val[N];
   assign r_nxt     = q_bit ? d_val[N-1:0] : t_val[N-1:0];
   assign q_nxt     = {q_r[N-2:0], q_bit};
   assign last_step = (cnt_r == '0);

`ifdef DIVIDER_SEQ_DIVZERO_EN
   assign div_zero_c = (bus.divisor == '0);
`else
   assign div_zero_c = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_r <= IDLE;
      else     state_r <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state_r;
      case (state_r)
         IDLE:    if (bus.start) state_nxt = div_zero_c ? DONE : RUN;
         RUN:     if (last_step) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r       <= '0;
         rem_r       <= '0;
         q_r         <= '0;
         dsr_r       <= '0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         quotient_r  <= '0;
         remainder_r <= '0;
         dbz_r       <= 1'b0;
      end else begin
         busy_r <= (state_nxt != IDLE);
         done_r <= (state_nxt == DONE);
         case (state_r)
            IDLE: begin
               if (bus.start) begin
                  dsr_r <= bus.divisor;
                  rem_r <= '0;
                  q_r   <= bus.dividend;
                  cnt_r <= CW'(N - 1);
                  dbz_r <= div_zero_c;
                  if (div_zero_c) begin
                     quotient_r  <= '1;
                     remainder_r <= bus.dividend;
                  end
               end
            end
            RUN: begin
               rem_r <= r_nxt;
               q_r   <= q_nxt;
               cnt_r <= cnt_r - CW'(1);
               if (last_step) begin
                  quotient_r  <= q_nxt;
                  remainder_r <= r_nxt;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.quotient  = quotient_r;
   assign bus.remainder = remainder_r;
`ifdef DIVIDER_SEQ_DIVZERO_EN
   assign bus.div_by_zero = dbz_r;
`else
   assign bus.div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_divider_seq_n.sv
// Directed self-checking bench for divider_seq_n (N=32).
// Zero-divisor expectations follow DIVIDER_SEQ_DIVZERO_EN when it is defined.
module tb_divider_seq_n;
   localparam int unsigned N = 32;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   divider_seq_n_if #(.N(N)) bus ();

   divider_seq_n #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one operation and wait (bounded) for done; lat = edges after the accept edge.
   task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                         output int lat, output logic [N-1:0] q, output logic [N-1:0] r,
                         output logic dbz, output logic busy_all);
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      lat       = 0;
      busy_all  = 1'b1;
      while (bus.done !== 1'b1 && lat < 100) begin
         if (bus.busy !== 1'b1) busy_all = 1'b0;
         @(negedge clk);
         lat++;
      end
      if (bus.busy !== 1'b1) busy_all = 1'b0;
      if (lat >= 100) lat = -1;
      q   = bus.quotient;
      r   = bus.remainder;
      dbz = bus.div_by_zero;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.start = 1'b0;
      bus.dividend = '0;
      bus.divisor = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000 || bus.quotient !== '0 || bus.remainder !== '0) begin
         errors++;
         $display("FAIL reset_state: busy=%b done=%b dbz=%b q=%h r=%h, required all 0",
                  bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int lat; logic [N-1:0] q, r; logic dbz, ba;
      run_op(32'd100, 32'd7, lat, q, r, dbz, ba);
      checks++;
      if (lat !== 32) begin errors++; $display("FAIL basic_latency: got %0d required 32", lat); end
      checks++;
      if (q !== 32'd14 || r !== 32'd2) begin
         errors++; $display("FAIL basic_result: q=%0d r=%0d required q=14 r=2", q, r);
      end
      checks++;
      if (ba !== 1'b1) begin errors++; $display("FAIL basic_busy: busy dropped during operation"); end
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0) begin errors++; $display("FAIL done_pulse: done=%b required 0 after one cycle", bus.done); end
      repeat (3) @(negedge clk);
      checks++;
      if (bus.quotient !== 32'd14 || bus.remainder !== 32'd2 || bus.busy !== 1'b0) begin
         errors++; $display("FAIL result_hold: q=%0d r=%0d busy=%b required 14 2 0", bus.quotient, bus.remainder, bus.busy);
      end
   endtask

   task automatic test_back_to_back();
      int lat; logic [N-1:0] q, r; logic dbz, ba;
      run_op(32'd3, 32'd10, lat, q, r, dbz, ba);
      checks++;
      if (lat !== 32 || q !== 32'd0 || r !== 32'd3) begin
         errors++; $display("FAIL b2b_first: lat=%0d q=%0d r=%0d required 32 0 3", lat, q, r);
      end
      run_op(32'hFFFF_FFFF, 32'd1, lat, q, r, dbz, ba);
      checks++;
      if (lat !== 32 || q !== 32'hFFFF_FFFF || r !== 32'd0) begin
         errors++; $display("FAIL b2b_second: lat=%0d q=%h r=%h required 32 ffffffff 0", lat, q, r);
      end
   endtask

   task automatic test_div_zero();
      int lat; logic [N-1:0] q, r; logic dbz, ba;
      int exp_lat; logic exp_dbz;
`ifdef DIVIDER_SEQ_DIVZERO_EN
      exp_lat = 0; exp_dbz = 1'b1;
`else
      exp_lat = 32; exp_dbz = 1'b0;
`endif
      run_op(32'd5, 32'd0, lat, q, r, dbz, ba);
      checks++;
      if (lat !== exp_lat) begin errors++; $display("FAIL divzero_latency: got %0d required %0d", lat, exp_lat); end
      checks++;
      if (q !== 32'hFFFF_FFFF || r !== 32'd5 || dbz !== exp_dbz) begin
         errors++; $display("FAIL divzero_result: q=%h r=%0d dbz=%b required ffffffff 5 %b", q, r, dbz, exp_dbz);
      end
      run_op(32'd20, 32'd6, lat, q, r, dbz, ba);
      checks++;
      if (dbz !== 1'b0 || q !== 32'd3 || r !== 32'd2) begin
         errors++; $display("FAIL divzero_clear: dbz=%b q=%0d r=%0d required 0 3 2", dbz, q, r);
      end
   endtask

   task automatic test_ignore_start();
      int dones; logic [N-1:0] q, r;
      dones = 0; q = '0; r = '0;
      @(negedge clk);
      bus.start = 1'b1; bus.dividend = 32'd100; bus.divisor = 32'd7;
      @(posedge clk);
      for (int i = 0; i < 45; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin dones++; q = bus.quotient; r = bus.remainder; end
         bus.dividend = 32'd9; bus.divisor = 32'd2;
         bus.start = (i < 28) && (i % 2 == 0);
      end
      bus.start = 1'b0;
      checks++;
      if (dones !== 1 || q !== 32'd14 || r !== 32'd2) begin
         errors++; $display("FAIL ignore_start: dones=%0d q=%0d r=%0d required 1 14 2", dones, q, r);
      end
   endtask

   task automatic test_mid_reset();
      int lat, dones; logic [N-1:0] q, r; logic dbz, ba;
      @(negedge clk);
      bus.start = 1'b1; bus.dividend = 32'd1000; bus.divisor = 32'd3;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000 || bus.quotient !== '0 || bus.remainder !== '0) begin
         errors++; $display("FAIL mid_reset_outputs: busy=%b done=%b dbz=%b q=%h r=%h required all 0",
                            bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
      end
      @(negedge clk);
      rst = 1'b0;
      dones = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
      end
      checks++;
      if (dones !== 0) begin errors++; $display("FAIL mid_reset_no_done: saw %0d active cycles required 0", dones); end
      run_op(32'd1000, 32'd3, lat, q, r, dbz, ba);
      checks++;
      if (lat !== 32 || q !== 32'd333 || r !== 32'd1) begin
         errors++; $display("FAIL mid_reset_fresh: lat=%0d q=%0d r=%0d required 32 333 1", lat, q, r);
      end
   endtask

   task automatic test_random();
      int lat; logic [N-1:0] q, r, a, b, eq, er; logic dbz, ba;
      for (int i = 0; i < 8; i++) begin
         a = $urandom;
         b = $urandom >> $urandom_range(0, 31);
         if (b == '0) b = 32'd1;
         eq = a / b;
         er = a % b;
         run_op(a, b, lat, q, r, dbz, ba);
         checks++;
         if (lat !== 32 || q !== eq || r !== er || r >= b || (q * b + r) !== a) begin
            errors++; $display("FAIL random_%0d: %h/%h lat=%0d q=%h r=%h required q=%h r=%h", i, a, b, lat, q, r, eq, er);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_div_zero();
      test_ignore_start();
      test_mid_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
